dma_fifo_burst: RTL and testbench

Parametrised single-clock DMA output FIFO, the successor to the fixed 16→32-bit channel FIFO. It packs narrow producer words into wide CPU-side words and raises a burst-granular DREQ whenever a full burst is buffered. It also offers a PIO read mode, fill level, sticky overflow/underflow flags, and a pessimistic "really empty" status. One instance sits per DMA channel, between the compressor/sensor data path (write side) and the CPU bus interface (read side).

---
 rtl/dma_fifo_burst.sv | 150 +++++++++++++++
 tb/tb_dma_fifo_burst.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_fifo_burst.sv
// DMA output FIFO: packs RATIO narrow producer words into one wide word and
// raises a burst-granular DREQ; also supports PIO reads, level and sticky status.
module dma_fifo_burst #(
    parameter int IN_W      = 16,
    parameter int RATIO     = 2,
    parameter int ADDR_W    = 9,
    parameter int BURST_LOG = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic                    cfg_en,
    input  logic                    cfg_pio,
    input  logic                    we,
    input  logic [IN_W-1:0]         di,
    output logic                    full,
    output logic                    dreq,
    input  logic                    dack,
    input  logic                    rd,
    output logic [IN_W*RATIO-1:0]   dout,
    output logic                    enabled,
    output logic [ADDR_W:0]         level,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    real_empty
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int BURST = 1 << BURST_LOG;
    localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int BW    = BURST_LOG + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST} state_t;

    logic              en, pio;
    logic              en_nxt, active;
    logic [ADDR_W-1:0] wptr, rptr;
    logic [ADDR_W:0]   level_nxt;
    logic [PW-1:0]     pcnt;
    logic [OUT_W-1:0]  pack, pack_nxt;
    logic              rd_req, rd_ok, wr_ok, wr_done, idle_cond;
    state_t            state;
    logic [BW-1:0]     bcnt;
    logic [3:0]        empty_sr;
    logic [OUT_W-1:0]  mem [DEPTH];

    assign enabled    = en;
    assign real_empty = empty_sr[3];
    assign dout       = mem[rptr];

    // Ops are gated on both the current and next enable so the cycle that
    // disables the channel (and the cycle that re-enables it) do nothing.
    always_comb begin
        en_nxt    = cfg_we ? cfg_en : en;
        active    = en && en_nxt;
        rd_req    = active && rd && (pio || dack);
        rd_ok     = rd_req && (level != '0);
        wr_ok     = active && we && !full;
        wr_done   = wr_ok && (pcnt == PW'(RATIO - 1));
        pack_nxt  = pack;
        pack_nxt[pcnt*IN_W +: IN_W] = di;
        idle_cond = en && (level == '0) && (pcnt == '0) && (state == S_IDLE);
        level_nxt = level;
        if (wr_done && !rd_ok)
            level_nxt = level + (ADDR_W+1)'(1);
        else if (rd_ok && !wr_done)
            level_nxt = level - (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en  <= 1'b0;
            pio <= 1'b0;
        end else if (cfg_we) begin
            en  <= cfg_en;
            pio <= cfg_pio;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_done)
            mem[wptr] <= pack_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0; rptr <= '0; level <= '0; full <= 1'b0;
            pcnt <= '0; pack <= '0;
            state <= S_IDLE; dreq <= 1'b0; bcnt <= '0;
            overflow <= 1'b0; underflow <= 1'b0; empty_sr <= '0;
        end else if (!en_nxt || !en) begin
            wptr <= '0; rptr <= '0; level <= '0; full <= 1'b0;
            pcnt <= '0; pack <= '0;
            state <= S_IDLE; dreq <= 1'b0; bcnt <= '0;
            overflow <= 1'b0; underflow <= 1'b0; empty_sr <= '0;
        end else begin
            if (active && we && full)
                overflow <= 1'b1;
            if (rd_req && level == '0)
                underflow <= 1'b1;

            if (wr_ok) begin
                pack <= pack_nxt;
                if (wr_done) begin
                    pcnt <= '0;
                    wptr <= wptr + ADDR_W'(1);
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
            end
            if (rd_ok)
                rptr <= rptr + ADDR_W'(1);
            level <= level_nxt;
            full  <= (level_nxt == (ADDR_W+1)'(DEPTH));

            if (pio) begin
                state <= S_IDLE;
                dreq  <= 1'b0;
                bcnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: if (level >= (ADDR_W+1)'(BURST)) begin
                        state <= S_REQ;
                        dreq  <= 1'b1;
                    end
                    S_REQ: if (rd_ok) begin
                        dreq  <= 1'b0;
                        state <= (BURST == 1) ? S_IDLE : S_BURST;
                        bcnt  <= (BURST == 1) ? '0 : BW'(1);
                    end
                    S_BURST: if (rd_ok) begin
                        // A dack gap simply stalls here; only BURST reads end it.
                        if (bcnt == BW'(BURST - 1)) begin
                            state <= S_IDLE;
                            bcnt  <= '0;
                        end else begin
                            bcnt <= bcnt + BW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        dreq  <= 1'b0;
                    end
                endcase
            end

            empty_sr <= idle_cond ? {empty_sr[2:0], 1'b1} : 4'b0000;
        end
    end
endmodule

// File: tb/tb_dma_fifo_burst.sv
// Directed bench for dma_fifo_burst at default parameters: a vector table for the
// basic fill/burst/drain flow, then hand-written multi-cycle corner sequences.
module tb_dma_fifo_burst;
    logic        clk, rst, cfg_we, cfg_en, cfg_pio, we, rd, dack;
    logic [15:0] di;
    logic        full, dreq, enabled, overflow, underflow, real_empty;
    logic [31:0] dout;
    logic [9:0]  level;
    int          ntests = 0;
    int          nfail  = 0;

    dma_fifo_burst dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_en(cfg_en), .cfg_pio(cfg_pio),
        .we(we), .di(di), .full(full), .dreq(dreq), .dack(dack), .rd(rd),
        .dout(dout), .enabled(enabled), .level(level), .overflow(overflow),
        .underflow(underflow), .real_empty(real_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic        cfg_we, cfg_en, cfg_pio, we;
        logic [15:0] di;
        logic        rd, dack;
        logic [9:0]  e_level;
        logic        e_dreq, e_re, chk_do;
        logic [31:0] e_dout;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] d);
        we = 1'b1; di = d;
        step();
        we = 1'b0;
    endtask

    task automatic rdp(input logic ack);
        rd = 1'b1; dack = ack;
        step();
        rd = 1'b0; dack = 1'b0;
    endtask

    task automatic cfg(input logic e, input logic p);
        cfg_we = 1'b1; cfg_en = e; cfg_pio = p;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 0; cfg_en = 0; cfg_pio = 0; we = 0; rd = 0; dack = 0; di = '0;
        step(); step();
        chk("reset level", level, 0);
        chk("reset dreq", dreq, 0);
        chk("reset full", full, 0);
        chk("reset enabled", enabled, 0);
        chk("reset flags", {overflow, underflow, real_empty}, 0);
        rst = 1'b0;
        step();

        // Table: enable, 16 writes, DREQ, 8-read burst, real_empty after 4 idle cycles
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 32'h0});
        for (int i = 1; i <= 16; i++)
            vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'(i), 1'b0, 1'b0, 10'(i/2), 1'b0, 1'b0,
                             (i == 16), 32'h0002_0001});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 10'd8, 1'b1, 1'b0, 1'b1, 32'h0002_0001});
        for (int j = 0; j < 8; j++)
            vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 10'(7-j), 1'b0, 1'b0,
                             (j < 7), {16'(2*j+4), 16'(2*j+3)}});
        for (int k = 0; k < 4; k++)
            vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 10'd0, 1'b0, (k == 3), 1'b0, 32'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            cfg_we = vecs[i].cfg_we; cfg_en = vecs[i].cfg_en; cfg_pio = vecs[i].cfg_pio;
            we = vecs[i].we; di = vecs[i].di; rd = vecs[i].rd; dack = vecs[i].dack;
            step();
            chk($sformatf("v%0d level", i), level, vecs[i].e_level);
            chk($sformatf("v%0d dreq", i), dreq, vecs[i].e_dreq);
            chk($sformatf("v%0d real_empty", i), real_empty, vecs[i].e_re);
            if (vecs[i].chk_do)
                chk($sformatf("v%0d dout", i), dout, vecs[i].e_dout);
        end
        cfg_we = 0; we = 0; rd = 0; dack = 0;

        // 15 words: one partial word left in the packer
        for (int k = 0; k < 15; k++) wr(16'(16'h100 + k));
        repeat (6) step();
        chk("odd level", level, 7);
        chk("odd dreq", dreq, 0);
        chk("odd real_empty", real_empty, 0);
        cfg(1'b0, 1'b0);
        chk("flush level", level, 0);
        chk("flush enabled", enabled, 0);

        // PIO: offset pointers, fill to full, overflow, drain across the wrap
        cfg(1'b1, 1'b1);
        for (int k = 0; k < 6; k++) wr(16'(16'hA0 + k));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("pio pre dout%0d", k), dout, {16'(16'hA1 + 2*k), 16'(16'hA0 + 2*k)});
            rdp(1'b0);
        end
        chk("pio pre level", level, 0);
        for (int k = 0; k < 1024; k++) begin
            if (k == 1023) chk("almost full", full, 0);
            wr(16'(k));
        end
        chk("fill level", level, 512);
        chk("fill full", full, 1);
        chk("pio dreq", dreq, 0);
        chk("pre overflow", overflow, 0);
        wr(16'hFFFF);
        chk("overflow flag", overflow, 1);
        chk("overflow level", level, 512);
        for (int k = 0; k < 512; k++) begin
            chk($sformatf("drain dout%0d", k), dout, {16'(2*k+1), 16'(2*k)});
            rdp(1'b0);
            if (k == 0) begin
                chk("drain full", full, 0);
                chk("drain level", level, 511);
            end
        end
        chk("drained level", level, 0);
        chk("pre underflow", underflow, 0);
        rdp(1'b0);
        chk("underflow flag", underflow, 1);
        chk("underflow level", level, 0);
        chk("overflow sticky", overflow, 1);

        // Burst with a dack gap: level 16, 3 reads, 5 stalled cycles, 5 reads
        cfg(1'b0, 1'b0);
        chk("flush flags", {overflow, underflow}, 0);
        cfg(1'b1, 1'b0);
        for (int k = 0; k < 32; k++) wr(16'(k + 1));
        chk("gap level", level, 16);
        chk("gap dreq", dreq, 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("gap dout%0d", k), dout, {16'(2*k+2), 16'(2*k+1)});
            rdp(1'b1);
            chk($sformatf("gap dreq%0d", k), dreq, 0);
        end
        rd = 1'b1; dack = 1'b0;
        repeat (5) step();
        rd = 1'b0;
        chk("stall level", level, 13);
        chk("stall dreq", dreq, 0);
        chk("stall underflow", underflow, 0);
        chk("resume dout", dout, 32'h0008_0007);
        for (int k = 1; k <= 5; k++) begin
            rdp(1'b1);
            chk($sformatf("resume level%0d", k), level, 10'(13 - k));
            chk($sformatf("resume dreq%0d", k), dreq, 0);
        end
        step();
        chk("rearm dreq", dreq, 1);

        // Asynchronous reset mid-burst with a partial word in the packer
        rdp(1'b1);
        wr(16'h55);
        chk("pre rst level", level, 7);
        rst = 1'b1;
        #2;
        chk("async rst level", level, 0);
        chk("async rst dreq", dreq, 0);
        chk("async rst enabled", enabled, 0);
        chk("async rst flags", {full, overflow, underflow, real_empty}, 0);
        step();
        rst = 1'b0;
        step();

        // Disable mid-burst, then confirm a clean restart
        cfg(1'b1, 1'b0);
        for (int k = 0; k < 16; k++) wr(16'(16'h200 + k));
        step();
        chk("dis dreq", dreq, 1);
        rdp(1'b1); rdp(1'b1);
        chk("dis pre level", level, 6);
        cfg(1'b0, 1'b0);
        chk("dis level", level, 0);
        chk("dis dreq0", dreq, 0);
        chk("dis enabled", enabled, 0);
        cfg(1'b1, 1'b0);
        chk("reen level", level, 0);
        for (int k = 0; k < 16; k++) wr(16'(16'h300 + k));
        chk("reen head", dout, 32'h0301_0300);
        chk("reen level8", level, 8);
        step();
        chk("reen dreq", dreq, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
